// File: rtl/dcache_2way_pkg.sv
// rtl/dcache_2way_pkg.sv - shared state encoding, word width and address-field widths for dcache_2way
package dcache_2way_pkg;

    localparam int WORD_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WRITEBACK = 2'd1;
    localparam state_t ST_ALLOCATE  = 2'd2;
    localparam state_t ST_UPDATE    = 2'd3;

    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_w, input int num_sets);
        return addr_w - off_w(line_w) - idx_w(num_sets);
    endfunction

endpackage

// File: rtl/dcache_2way_sram.sv
// rtl/dcache_2way_sram.sv - one cache way: valid/dirty flags, tag and line arrays, single write port, async read
module dcache_2way_sram #(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 23,
    parameter int LINE_W   = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  index,
    input  logic              we,
    input  logic              wr_valid,
    input  logic              wr_dirty,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   line_q [NUM_SETS];

    // Only the status flags are reset; tag and line contents are don't-care while invalid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[index] <= wr_valid;
            dirty_q[index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_q[index]  <= wr_tag;
            line_q[index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = line_q[index];

endmodule

// File: rtl/dcache_2way.sv
// rtl/dcache_2way.sv - two-way set-associative write-back, write-allocate data cache with LRU replacement
module dcache_2way
    import dcache_2way_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic              mem_ack_i
);

    localparam int OFF_W = off_w(LINE_W);
    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int TAG_W = tag_w(ADDR_W, LINE_W, NUM_SETS);
    localparam int SEL_W = OFF_W - 2;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [SEL_W-1:0]  wsel;
    logic              unused_byte_bits;

    assign idx  = p1_addr_i[OFF_W +: IDX_W];
    assign tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel = p1_addr_i[OFF_W-1:2];
    assign unused_byte_bits = ^p1_addr_i[1:0];

    state_t              state;
    logic                victim;
    logic [NUM_SETS-1:0] lru;

    logic [1:0]          we;
    logic                wr_valid;
    logic                wr_dirty;
    logic [TAG_W-1:0]    wr_tag;
    logic [LINE_W-1:0]   wr_line;
    logic [1:0]          rd_valid;
    logic [1:0]          rd_dirty;
    logic [TAG_W-1:0]    rd_tag  [2];
    logic [LINE_W-1:0]   rd_line [2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_2way_sram #(
            .NUM_SETS (NUM_SETS),
            .IDX_W    (IDX_W),
            .TAG_W    (TAG_W),
            .LINE_W   (LINE_W)
        ) u_way (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .index    (idx),
            .we       (we[w]),
            .wr_valid (wr_valid),
            .wr_dirty (wr_dirty),
            .wr_tag   (wr_tag),
            .wr_line  (wr_line),
            .rd_valid (rd_valid[w]),
            .rd_dirty (rd_dirty[w]),
            .rd_tag   (rd_tag[w]),
            .rd_line  (rd_line[w])
        );
    end

    logic [1:0]        hit_way;
    logic              hit;
    logic              req;
    logic              sel_way;
    logic              victim_sel;
    logic              victim_dirty;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] store_line;

    assign hit_way[0]   = rd_valid[0] && (rd_tag[0] == tag);
    assign hit_way[1]   = rd_valid[1] && (rd_tag[1] == tag);
    assign hit          = |hit_way;
    assign sel_way      = hit_way[1];
    assign req          = p1_MemRead_i | p1_MemWrite_i;
    assign hit_line     = rd_line[sel_way];
    assign victim_sel   = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru[idx]);
    assign victim_dirty = rd_valid[victim_sel] & rd_dirty[victim_sel];

    always_comb begin
        store_line = hit_line;
        store_line[wsel*WORD_W +: WORD_W] = p1_data_i;
    end

    assign p1_stall_o = rst_i & ((state != ST_IDLE) | (req & ~hit));
    assign p1_data_o  = (rst_i & hit) ? hit_line[wsel*WORD_W +: WORD_W] : '0;

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag[victim], idx, {OFF_W{1'b0}}};
                mem_data_o   = rd_line[victim];
            end
            ST_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

    // Refill line lands at ack with the way still invalid; UPDATE then marks it valid and clean.
    always_comb begin
        we       = '0;
        wr_valid = 1'b0;
        wr_dirty = 1'b0;
        wr_tag   = tag;
        wr_line  = mem_data_i;
        case (state)
            ST_IDLE: begin
                if (req && hit && p1_MemWrite_i) begin
                    we[sel_way] = 1'b1;
                    wr_valid    = 1'b1;
                    wr_dirty    = 1'b1;
                    wr_line     = store_line;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ack_i) begin
                    we[victim] = 1'b1;
                end
            end
            ST_UPDATE: begin
                we[victim] = 1'b1;
                wr_valid   = 1'b1;
                wr_line    = rd_line[victim];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            victim <= 1'b0;
            lru    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            lru[idx] <= hit_way[0];
                        end else begin
                            victim <= victim_sel;
                            state  <= victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: if (mem_ack_i) state <= ST_ALLOCATE;
                ST_ALLOCATE:  if (mem_ack_i) state <= ST_UPDATE;
                ST_UPDATE: begin
                    lru[idx] <= ~victim;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_2way.sv
// tb/tb_dcache_2way.sv - directed self-checking bench for dcache_2way with a fixed-latency line memory
module tb_dcache_2way;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic         rd = 1'b0;
    logic         wr = 1'b0;
    logic [31:0]  rdata;
    logic         stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_en;
    logic         mem_we;
    logic         mem_ack;

    logic         auto_ack = 1'b1;
    logic         resp_ack = 1'b0;
    logic         force_ack = 1'b0;
    int           lat_cnt = 0;
    int           rd_count = 0;
    int           wb_count = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;

    int total = 0;
    int bad = 0;

    assign mem_ack = resp_ack | force_ack;

    always #5 clk = ~clk;

    dcache_2way #(
        .NUM_SETS (16),
        .ADDR_W   (32),
        .LINE_W   (256)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p1_addr_i     (addr),
        .p1_data_i     (wdata),
        .p1_MemRead_i  (rd),
        .p1_MemWrite_i (wr),
        .p1_data_o     (rdata),
        .p1_stall_o    (stall),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_data_i    (mem_rdata),
        .mem_enable_o  (mem_en),
        .mem_write_o   (mem_we),
        .mem_ack_i     (mem_ack)
    );

    function automatic logic [255:0] pat_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA500_0000 | (a + 32'(4 * k));
        return l;
    endfunction

    // Memory acks on the fifth cycle it sees a request.
    initial begin
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (auto_ack && rst && mem_en) begin
                lat_cnt++;
                if (lat_cnt == 5) begin
                    lat_cnt  = 0;
                    resp_ack = 1'b1;
                    if (mem_we) begin
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                        wb_count++;
                    end else begin
                        last_rd_addr = mem_addr;
                        mem_rdata    = pat_line(mem_addr);
                        rd_count++;
                    end
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] q);
        @(negedge clk);
        addr = a; wdata = d; rd = r; wr = w; stalls = 0;
        #1;
        while (stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        q = rdata;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int s;
        logic [31:0] q;
        logic [255:0] exp_line;
        int rc;

        // reset held with a pending load
        addr = 32'h40; rd = 1'b1;
        #12;
        check("rst_stall", stall, 0);
        check("rst_en", mem_en, 0);
        check("rst_we", mem_we, 0);
        check("rst_rdata", rdata, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mdata", mem_wdata, 0);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_en", mem_en, 0);

        // cold load
        access(1, 0, 32'h40, 0, s, q);
        check("cold_stall", s, 7);
        check("cold_data", q, 32'hA500_0040);
        check("cold_raddr", last_rd_addr, 32'h40);
        check("cold_wbcnt", wb_count, 0);

        // store hit, then reload
        access(0, 1, 32'h44, 32'hDEAD_BEEF, s, q);
        check("st_stall", s, 0);
        access(1, 0, 32'h44, 0, s, q);
        check("ld44_stall", s, 0);
        check("ld44_data", q, 32'hDEAD_BEEF);
        access(1, 0, 32'h5C, 0, s, q);
        check("ld5c_data", q, 32'hA500_005C);

        // fill way1, then dirty eviction of 0x40
        access(1, 0, 32'h240, 0, s, q);
        check("f240_stall", s, 7);
        check("f240_data", q, 32'hA500_0240);
        access(1, 0, 32'h440, 0, s, q);
        exp_line = pat_line(32'h40);
        exp_line[63:32] = 32'hDEAD_BEEF;
        check("wb_stall", s, 12);
        check("wb_addr", last_wb_addr, 32'h40);
        check("wb_data", last_wb_data, exp_line);
        check("wb_cnt", wb_count, 1);
        check("f440_raddr", last_rd_addr, 32'h440);
        check("f440_data", q, 32'hA500_0440);
        access(1, 0, 32'h240, 0, s, q);
        check("keep240_stall", s, 0);

        // hit on 0x40 between fills makes 0x240 the victim
        do_reset();
        access(1, 0, 32'h40, 0, s, q);
        check("l2_f40", s, 7);
        access(1, 0, 32'h240, 0, s, q);
        check("l2_f240", s, 7);
        access(1, 0, 32'h40, 0, s, q);
        check("l2_hit40", s, 0);
        access(1, 0, 32'h440, 0, s, q);
        check("l2_f440", s, 7);
        check("l2_wbcnt", wb_count, 1);
        access(1, 0, 32'h40, 0, s, q);
        check("l2_keep40", s, 0);
        check("l2_data40", q, 32'hA500_0040);
        access(1, 0, 32'h240, 0, s, q);
        check("l2_miss240", s, 7);

        // reset in the middle of a refill, then a stray ack
        do_reset();
        auto_ack = 1'b0;
        @(negedge clk);
        addr = 32'h40; rd = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mid_en", mem_en, 1);
        check("mid_we", mem_we, 0);
        check("mid_addr", mem_addr, 32'h40);
        rst = 1'b0;
        #1;
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_stall", stall, 0);
        @(negedge clk);
        rd = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        #1;
        check("stray_en", mem_en, 0);
        check("stray_stall", stall, 0);
        auto_ack = 1'b1;
        rc = rd_count;
        access(1, 0, 32'h40, 0, s, q);
        check("re_miss_stall", s, 7);
        check("re_miss_cnt", rd_count, rc + 1);

        // read and write together act as a store
        access(1, 1, 32'h44, 32'h1234_5678, s, q);
        check("rw_stall", s, 0);
        access(1, 0, 32'h44, 0, s, q);
        check("rw_data", q, 32'h1234_5678);
        access(1, 0, 32'h240, 0, s, q);
        access(1, 0, 32'h440, 0, s, q);
        exp_line = pat_line(32'h40);
        exp_line[63:32] = 32'h1234_5678;
        check("rw_wb_stall", s, 12);
        check("rw_wb_addr", last_wb_addr, 32'h40);
        check("rw_wb_data", last_wb_data, exp_line);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, number of sets (power of two, 2..256).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter LINE_W, default 256, line width in bits; word width fixed 32.
REQ-004 SHALL have port clk_i, input, 1: single clock, all state rising-edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port p1_addr_i, input, ADDR_W: CPU byte address.
REQ-007 SHALL have port p1_data_i, input, 32: CPU store data.
REQ-008 SHALL have port p1_MemRead_i, input, 1: load request.
REQ-009 SHALL have port p1_MemWrite_i, input, 1: store request.
REQ-010 SHALL have port p1_data_o, output, 32: load data.
REQ-011 SHALL have port p1_stall_o, output, 1: pipeline freeze.
REQ-012 SHALL have port mem_addr_o, output, ADDR_W: line-aligned memory address.
REQ-013 SHALL have port mem_data_o, output, LINE_W: writeback line.
REQ-014 SHALL have port mem_data_i, input, LINE_W: refill line.
REQ-015 SHALL have port mem_enable_o, output, 1: memory request.
REQ-016 SHALL have port mem_write_o, output, 1: 1 = line write, 0 = line read.
REQ-017 SHALL have port mem_ack_i, input, 1: one-cycle completion pulse.

Function
REQ-018 Address split SHALL be: offset = low log2(LINE_W/8) bits, word select = offset[high:2], index = next log2(NUM_SETS) bits, tag = remainder.
REQ-019 Per set SHALL hold 2 ways of {valid, dirty, tag, line} plus one LRU bit (1 = way1 least recent).
REQ-020 Request = p1_MemRead_i | p1_MemWrite_i; both high SHALL be treated as a store.
REQ-021 Hit (valid and tag match in either way) SHALL complete with zero stall: load data combinational on p1_data_o, store writes word and sets dirty at next edge.
REQ-022 Every hit and every refill SHALL set LRU to point away from the accessed way.
REQ-023 Victim SHALL be: way0 if invalid, else way1 if invalid, else the LRU way.
REQ-024 p1_stall_o SHALL be high combinationally whenever a request misses or FSM is not IDLE, and low the cycle the retried access hits.
REQ-025 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, UPDATE.
REQ-026 IDLE -> WRITEBACK on miss with dirty victim; IDLE -> ALLOCATE on miss with clean/invalid victim.
REQ-027 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,0}, mem_data_o=victim line; on mem_ack_i -> ALLOCATE.
REQ-028 ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={request tag,index,0}; on mem_ack_i capture mem_data_i into victim way -> UPDATE.
REQ-029 UPDATE: victim way valid=1, dirty=0, tag written; one cycle -> IDLE, where access re-evaluates as hit (write-allocate for stores).
REQ-030 mem_enable_o SHALL be held constant with stable address/data until mem_ack_i; mem_ack_i outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-031 Clean miss latency SHALL be ack cycle + 2 cycles stall; dirty miss adds the writeback handshake.
REQ-032 In IDLE with no request, mem_enable_o=0, mem_write_o=0.

Reset
REQ-033 rst_i low SHALL immediately force FSM IDLE, mem_enable_o=0, mem_write_o=0, p1_stall_o=0, p1_data_o=0, mem_addr_o=0, mem_data_o=0.
REQ-034 rst_i low SHALL clear all valid, dirty and LRU bits; line/tag storage need not reset.
REQ-035 Reset mid-refill SHALL abandon the transfer; a later stray mem_ack_i SHALL be ignored.

Structure
REQ-036 Shared package SHALL hold FSM state enum, WORD_W=32, and address-field width functions.
REQ-037 One sub-module dcache_2way_sram (per-way tag/data array, one write port, async read) SHALL be instantiated per way; FSM and LRU stay in top.

Verification
REQ-038 Cold load 0x0000_0040, memory acks after 5 cycles -> ALLOCATE read addr 0x40, stall 7 cycles total, p1_data_o = refilled word 0.
REQ-039 Store 0xDEADBEEF to 0x44 after above -> no stall, way dirty; subsequent load 0x44 returns 0xDEADBEEF.
REQ-040 Loads 0x040, 0x240, 0x440 (same set, NUM_SETS=16) with 0x040 dirty -> third miss evicts LRU 0x040: WRITEBACK addr 0x040 with stored data, then ALLOCATE 0x440.
REQ-041 Hit 0x040 between fills of 0x240 and 0x440 -> 0x240 evicted instead.
REQ-042 rst_i low during ALLOCATE, then ack pulse after release -> mem_enable_o=0, no state change, load 0x040 misses again.
REQ-043 p1_MemRead_i and p1_MemWrite_i both high on hit 0x044 with 0x12345678 -> word written, dirty set.
